// File: rtl/cpu_decode_sequencer.sv
// cpu_decode_sequencer: accepts IR instructions and sequences exec1/exec2, skip squash and retire.
// Optional ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP until reset.
module cpu_decode_sequencer #(
   parameter logic [5:0] LAST_OPCODE  = 6'h38,
   parameter int         WAIT_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [15:0] instr_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic        skipstatus_i,
   input  logic        mem_wait_i,
   output logic [5:0]  decoder_encoded_opcode_o,
   output logic        exec1_o,
   output logic        exec2_o,
   output logic        aim_o,
   output logic        sim_o,
   output logic        skip_clr_o,
   output logic        retire_o,
   output logic        illegal_o,
   output logic        timeout_o
);
   typedef enum logic [2:0] {IDLE, DECODE, EXEC1, EXEC2, DONE, TRAP} state_t;

   state_t      state_q, state_d;
   logic [5:0]  opc_q, opc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        skip_q, skip_d;
   logic        illegal_q, illegal_d;
   logic        timeout_q, timeout_d;
   logic        unused_instr;

   assign unused_instr = ^instr_i[9:0];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         opc_q     <= '0;
         cnt_q     <= '0;
         skip_q    <= 1'b0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         cnt_q     <= cnt_d;
         skip_q    <= skip_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      cnt_d     = cnt_q;
      skip_d    = skip_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: if (instr_valid_i) begin
            opc_d   = instr_i[15:10];
            skip_d  = 1'b0;
            state_d = DECODE;
         end
         DECODE: begin
            skip_d = skipstatus_i;
            if (skipstatus_i) state_d = DONE;
            else if (opc_q > LAST_OPCODE) begin
               // the ALU sees opcode 0 so an illegal instruction produces result 0
               illegal_d = 1'b1;
               opc_d     = '0;
`ifdef ILLEGAL_TRAP_EN
               state_d   = TRAP;
`else
               state_d   = DONE;
`endif
            end else state_d = EXEC1;
         end
         EXEC1: begin
            cnt_d   = '0;
            state_d = (opc_q inside {6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h21, 6'h22, 6'h24, 6'h26}) ? EXEC2 : DONE;
         end
         EXEC2: if (!mem_wait_i) state_d = DONE;
         else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(WAIT_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            skip_d  = 1'b0;
            state_d = IDLE;
         end
         TRAP: state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   assign instr_ready_o            = state_q == IDLE;
   assign decoder_encoded_opcode_o = opc_q;
   assign exec1_o                  = state_q == EXEC1;
   assign exec2_o                  = state_q == EXEC2;
   assign aim_o                    = (exec1_o | exec2_o) & (opc_q == 6'h0B);
   assign sim_o                    = (exec1_o | exec2_o) & (opc_q == 6'h0C);
   assign skip_clr_o               = (state_q == DONE) & skip_q;
   assign retire_o                 = state_q == DONE;
   assign illegal_o                = illegal_q;
   assign timeout_o                = timeout_q;
endmodule

// File: tb/tb_cpu_decode_sequencer.sv
// tb_cpu_decode_sequencer: vector table, random transactions against a transaction-level model, corner sequences.
module tb_cpu_decode_sequencer;
   localparam int WT = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        skipstatus = 1'b0;
   logic        mem_wait = 1'b0;
   logic        instr_ready, exec1, exec2, aim, sim, skip_clr, retire, illegal, timeout;
   logic [5:0]  opcode;

   int total = 0;
   int bad = 0;
   logic m_ill = 1'b0;
   logic m_to = 1'b0;

   typedef struct packed {
      logic [15:0] ins;
      logic        sk;
      logic [7:0]  nw;
      logic [7:0]  opc;
      logic [7:0]  e1;
      logic [7:0]  e2;
      logic [7:0]  lat;
      logic        aim;
      logic        sim;
      logic [7:0]  skc;
      logic        ill;
      logic        to;
   } vec_t;

   vec_t tbl[12];

   cpu_decode_sequencer #(.LAST_OPCODE(6'h38), .WAIT_TIMEOUT(WT)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .instr_i(instr), .instr_valid_i(instr_valid),
      .instr_ready_o(instr_ready), .skipstatus_i(skipstatus), .mem_wait_i(mem_wait),
      .decoder_encoded_opcode_o(opcode), .exec1_o(exec1), .exec2_o(exec2), .aim_o(aim),
      .sim_o(sim), .skip_clr_o(skip_clr), .retire_o(retire), .illegal_o(illegal), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      instr_valid = 1'b0;
      skipstatus = 1'b0;
      mem_wait = 1'b0;
      m_ill = 1'b0;
      m_to = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", instr_ready, 1);
      check("rst_outs", {exec1, exec2, aim, sim, skip_clr, retire, illegal, timeout}, 0);
      check("rst_opcode", opcode, 0);
      reset_n = 1'b1;
   endtask

   // transaction-level reference: outcome of one instruction from opcode, skip flag and wait count
   function automatic vec_t model(input logic [15:0] ins, input logic sk, input int nw);
      vec_t v;
      logic [5:0] op = ins[15:10];
      logic ill = !sk && op > 6'h38;
      logic ex = !sk && !ill;
      logic multi = ex && (op inside {6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h21, 6'h22, 6'h24, 6'h26});
      int e2 = !multi ? 0 : (nw >= WT ? WT : nw + 1);
      m_ill |= ill;
      m_to |= multi && nw >= WT;
      v.ins = ins;
      v.sk = sk;
      v.nw = 8'(nw);
      v.opc = ill ? 8'd0 : 8'(op);
      v.e1 = ex ? 8'd1 : 8'd0;
      v.e2 = 8'(e2);
      v.lat = ex ? 8'(3 + e2) : 8'd2;
      v.aim = ex && op == 6'h0B;
      v.sim = ex && op == 6'h0C;
      v.skc = sk ? 8'd2 : 8'd0;
      v.ill = m_ill;
      v.to = m_to;
      return v;
   endfunction

   // called at a negedge with the sequencer idle; returns at the negedge after retire
   task automatic apply(input vec_t v);
      int rc = 0, e1n = 0, e1c = 0, e2n = 0, scc = 0;
      logic aims = 0, sims = 0, busy_rdy = 0;
      logic [5:0] opc2 = '0;
      instr = v.ins;
      instr_valid = 1'b1;
      skipstatus = v.sk;
      mem_wait = 1'b0;
      @(posedge clk);
      #1 instr = 16'($urandom);
      for (int c = 1; c <= 60 && rc == 0; c++) begin
         @(negedge clk);
         if (exec1) begin e1n++; e1c = c; end
         if (exec2) e2n++;
         aims |= aim;
         sims |= sim;
         busy_rdy |= instr_ready;
         if (skip_clr) scc = c;
         if (retire) rc = c;
         if (c == 2) opc2 = opcode;
         mem_wait = exec2 && (e2n <= int'(v.nw));
      end
      check("retire_cycle", rc, v.lat);
      check("exec1_count", e1n, v.e1);
      check("exec1_cycle", e1c, v.e1 != 0 ? 2 : 0);
      check("exec2_count", e2n, v.e2);
      check("aim_seen", aims, v.aim);
      check("sim_seen", sims, v.sim);
      check("skip_clr_cycle", scc, v.skc);
      check("opcode", opc2, v.opc);
      check("ready_while_busy", busy_rdy, 0);
      @(negedge clk);
      check("ready_after", instr_ready, 1);
      check("illegal_flag", illegal, v.ill);
      check("timeout_flag", timeout, v.to);
      instr_valid = 1'b0;
      mem_wait = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{16'h4400, 1'b0, 8'd0,  8'h11, 8'd1, 8'd0,  8'd3,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[1]  = '{16'h8400, 1'b0, 8'd0,  8'h21, 8'd1, 8'd1,  8'd4,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[2]  = '{16'h6800, 1'b0, 8'd5,  8'h1A, 8'd1, 8'd6,  8'd9,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[3]  = '{16'h2C00, 1'b0, 8'd0,  8'h0B, 8'd1, 8'd0,  8'd3,  1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[4]  = '{16'h3000, 1'b0, 8'd0,  8'h0C, 8'd1, 8'd0,  8'd3,  1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
      tbl[5]  = '{16'h2C00, 1'b1, 8'd0,  8'h0B, 8'd0, 8'd0,  8'd2,  1'b0, 1'b0, 8'd2, 1'b0, 1'b0};
      tbl[6]  = '{16'hE000, 1'b0, 8'd0,  8'h38, 8'd1, 8'd0,  8'd3,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[7]  = '{16'h9800, 1'b0, 8'd2,  8'h26, 8'd1, 8'd3,  8'd6,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[8]  = '{16'h6400, 1'b0, 8'd0,  8'h19, 8'd1, 8'd1,  8'd4,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[9]  = '{16'h8800, 1'b0, 8'd0,  8'h22, 8'd1, 8'd1,  8'd4,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[10] = '{16'h6800, 1'b0, 8'd15, 8'h1A, 8'd1, 8'd16, 8'd19, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[11] = '{16'h6800, 1'b0, 8'd40, 8'h1A, 8'd1, 8'd16, 8'd19, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 12; i++) apply(tbl[i]);

      do_reset();
      for (int i = 0; i < 150; i++) begin
         logic [15:0] ins = 16'($urandom);
         logic sk = ($urandom_range(0, 7) == 0);
         int nw = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 3);
`ifdef ILLEGAL_TRAP_EN
         if (ins[15:10] > 6'h38) sk = 1'b1;
`endif
         if ($urandom_range(0, 3) == 0) ins[15:10] = 6'h19 + 6'($urandom_range(0, 13));
         apply(model(ins, sk, nw));
      end

`ifdef ILLEGAL_TRAP_EN
      begin
         int rets = 0, e1s = 0, rdys = 0;
         instr = 16'hFC00;
         instr_valid = 1'b1;
         skipstatus = 1'b0;
         @(posedge clk);
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rets += int'(retire);
            e1s += int'(exec1 | exec2);
            rdys += int'(instr_ready);
         end
         check("trap_retire", rets, 0);
         check("trap_exec", e1s, 0);
         check("trap_ready", rdys, 0);
         check("trap_illegal", illegal, 1);
         check("trap_opcode", opcode, 0);
         instr_valid = 1'b0;
      end
`else
      apply(model(16'hFC00, 1'b0, 0));
      apply(model(16'h4400, 1'b0, 0));
`endif

      do_reset();
      instr = 16'h6800;
      instr_valid = 1'b1;
      mem_wait = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_exec2", exec2, 1);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_ready", instr_ready, 1);
      check("midreset_outs", {exec1, exec2, aim, sim, skip_clr, retire, illegal, timeout}, 0);
      check("midreset_opcode", opcode, 0);
      mem_wait = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", {instr_ready, retire}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
